// File: rtl/serial_frame_rx_if.sv
// rtl/serial_frame_rx_if.sv - received-word handshake bundle between serial_frame_rx and its consumer
interface serial_frame_rx_if #(
   parameter int DATA_W = 8
);
   logic [DATA_W-1:0] data;
   logic              valid;
   logic              ready;
   logic              frame_err;
   logic              overrun;

   modport master (output data, output valid, output frame_err, output overrun, input ready);
   modport slave  (input data, input valid, input frame_err, input overrun, output ready);
endinterface

// File: rtl/serial_frame_rx.sv
// rtl/serial_frame_rx.sv - serial frame receiver (start, DATA_W bits LSB first, stop) with valid/ready output
// Optional even-parity bit before stop when PARITY_CHECK_EN is defined.
module serial_frame_rx #(
   parameter int DATA_W = 8
) (
   input  logic                clk,
   input  logic                clr_n,
   input  logic                serial_in_i,
   input  logic                bit_en_i,
   serial_frame_rx_if.master   out_if
);
   localparam int CW = $clog2(DATA_W);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_DATA   = 2'd1,
`ifdef PARITY_CHECK_EN
      S_PARITY = 2'd3,
`endif
      S_STOP   = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [DATA_W-1:0] shift_q, shift_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic              valid_q, valid_d;
   logic              ferr_q, ferr_d;
   logic              ovr_q, ovr_d;
`ifdef PARITY_CHECK_EN
   logic              par_bad_q, par_bad_d;
`endif

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         shift_q   <= '0;
         data_q    <= '0;
         valid_q   <= 1'b0;
         ferr_q    <= 1'b0;
         ovr_q     <= 1'b0;
`ifdef PARITY_CHECK_EN
         par_bad_q <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         shift_q   <= shift_d;
         data_q    <= data_d;
         valid_q   <= valid_d;
         ferr_q    <= ferr_d;
         ovr_q     <= ovr_d;
`ifdef PARITY_CHECK_EN
         par_bad_q <= par_bad_d;
`endif
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      shift_d   = shift_q;
`ifdef PARITY_CHECK_EN
      par_bad_d = par_bad_q;
`endif
      if (bit_en_i) begin
         case (state_q)
            S_IDLE: begin
               if (!serial_in_i) begin
                  state_d   = S_DATA;
                  cnt_d     = '0;
`ifdef PARITY_CHECK_EN
                  par_bad_d = 1'b0;
`endif
               end
            end
            S_DATA: begin
               shift_d[cnt_q] = serial_in_i;
               cnt_d          = cnt_q + CW'(1);
               if (cnt_q == CW'(DATA_W - 1)) begin
`ifdef PARITY_CHECK_EN
                  state_d = S_PARITY;
`else
                  state_d = S_STOP;
`endif
               end
            end
`ifdef PARITY_CHECK_EN
            S_PARITY: begin
               par_bad_d = serial_in_i ^ (^shift_q);
               state_d   = S_STOP;
            end
`endif
            S_STOP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
         endcase
      end
   end

   logic stop_sample, good_frame, xfer;

   // The stop edge both classifies the frame and arbitrates it against the pending word.
   always_comb begin
      stop_sample = bit_en_i && (state_q == S_STOP);
`ifdef PARITY_CHECK_EN
      good_frame  = stop_sample && serial_in_i && !par_bad_q;
`else
      good_frame  = stop_sample && serial_in_i;
`endif
      xfer        = valid_q && out_if.ready;
      data_d      = data_q;
      valid_d     = valid_q;
      ferr_d      = stop_sample && !good_frame;
      ovr_d       = 1'b0;
      if (good_frame) begin
         if (!valid_q || out_if.ready) begin
            data_d  = shift_q;
            valid_d = 1'b1;
         end else begin
            ovr_d   = 1'b1;
         end
      end else if (xfer) begin
         valid_d = 1'b0;
      end
   end

   assign out_if.data      = data_q;
   assign out_if.valid     = valid_q;
   assign out_if.frame_err = ferr_q;
   assign out_if.overrun   = ovr_q;
endmodule

// File: tb/tb_serial_frame_rx.sv
// tb/tb_serial_frame_rx.sv - directed bench for serial_frame_rx (honours PARITY_CHECK_EN)
module tb_serial_frame_rx;
   logic clk = 1'b0;
   logic clr_n = 1'b0;
   logic serial_in = 1'b1;
   logic bit_en = 1'b0;
   int   n_checks = 0;
   int   n_fail = 0;

   serial_frame_rx_if #(.DATA_W(8)) bus ();

   serial_frame_rx #(.DATA_W(8)) dut (
      .clk         (clk),
      .clr_n       (clr_n),
      .serial_in_i (serial_in),
      .bit_en_i    (bit_en),
      .out_if      (bus)
   );

   always #5 clk = ~clk;

   // Caller is always at a negedge; returns at the negedge after the sampling posedge.
   task automatic drive_bit(input logic b, input int gap);
      repeat (gap) @(negedge clk);
      serial_in = b;
      bit_en    = 1'b1;
      @(negedge clk);
      bit_en    = 1'b0;
      serial_in = 1'b1;
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop, input logic par_flip,
                             input int gap, input logic rdy_stop);
      logic saved;
      drive_bit(1'b0, gap);
      for (int i = 0; i < 8; i++) drive_bit(d[i], gap);
`ifdef PARITY_CHECK_EN
      drive_bit((^d) ^ par_flip, gap);
`endif
      saved = bus.ready;
      repeat (gap) @(negedge clk);
      bus.ready = rdy_stop;
      drive_bit(stop, 0);
      bus.ready = saved;
   endtask

   task automatic drain;
      bus.ready = 1'b1;
      @(negedge clk);
      bus.ready = 1'b0;
   endtask

   task automatic test_reset;
      clr_n = 1'b0;
      bus.ready = 1'b0;
      repeat (2) @(negedge clk);
      n_checks++; if (bus.data !== 8'h00) begin n_fail++; $display("FAIL reset_data got %h exp 00", bus.data); end
      n_checks++; if (bus.valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b exp 0", bus.valid); end
      n_checks++; if (bus.frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_ferr got %b exp 0", bus.frame_err); end
      n_checks++; if (bus.overrun !== 1'b0) begin n_fail++; $display("FAIL reset_ovr got %b exp 0", bus.overrun); end
      clr_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_basic;
      bus.ready = 1'b1;
      send_frame(8'hA5, 1'b1, 1'b0, 0, 1'b1);
      n_checks++; if (bus.valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid got %b exp 1", bus.valid); end
      n_checks++; if (bus.data !== 8'hA5) begin n_fail++; $display("FAIL basic_data got %h exp a5", bus.data); end
      n_checks++; if (bus.frame_err !== 1'b0) begin n_fail++; $display("FAIL basic_ferr got %b exp 0", bus.frame_err); end
      n_checks++; if (bus.overrun !== 1'b0) begin n_fail++; $display("FAIL basic_ovr got %b exp 0", bus.overrun); end
      @(negedge clk);
      n_checks++; if (bus.valid !== 1'b0) begin n_fail++; $display("FAIL basic_valid_1cyc got %b exp 0", bus.valid); end
      bus.ready = 1'b0;
   endtask

   task automatic test_slow_hold;
      bus.ready = 1'b0;
      send_frame(8'h3C, 1'b1, 1'b0, 3, 1'b0);
      n_checks++; if (bus.data !== 8'h3C) begin n_fail++; $display("FAIL slow_data got %h exp 3c", bus.data); end
      repeat (10) @(negedge clk);
      n_checks++; if (bus.valid !== 1'b1) begin n_fail++; $display("FAIL slow_hold_valid got %b exp 1", bus.valid); end
      n_checks++; if (bus.data !== 8'h3C) begin n_fail++; $display("FAIL slow_hold_data got %h exp 3c", bus.data); end
      drain();
      n_checks++; if (bus.valid !== 1'b0) begin n_fail++; $display("FAIL slow_drain_valid got %b exp 0", bus.valid); end
      n_checks++; if (bus.data !== 8'h3C) begin n_fail++; $display("FAIL slow_drain_data got %h exp 3c", bus.data); end
   endtask

   task automatic test_overrun;
      bus.ready = 1'b0;
      send_frame(8'h11, 1'b1, 1'b0, 0, 1'b0);
      send_frame(8'h22, 1'b1, 1'b0, 0, 1'b0);
      n_checks++; if (bus.overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_pulse got %b exp 1", bus.overrun); end
      n_checks++; if (bus.data !== 8'h11) begin n_fail++; $display("FAIL ovr_data got %h exp 11", bus.data); end
      n_checks++; if (bus.frame_err !== 1'b0) begin n_fail++; $display("FAIL ovr_ferr got %b exp 0", bus.frame_err); end
      @(negedge clk);
      n_checks++; if (bus.overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_1cyc got %b exp 0", bus.overrun); end
      n_checks++; if (bus.valid !== 1'b1) begin n_fail++; $display("FAIL ovr_valid got %b exp 1", bus.valid); end
      drain();
      send_frame(8'h11, 1'b1, 1'b0, 0, 1'b0);
      send_frame(8'h22, 1'b1, 1'b0, 0, 1'b1);
      n_checks++; if (bus.data !== 8'h22) begin n_fail++; $display("FAIL b2b_data got %h exp 22", bus.data); end
      n_checks++; if (bus.valid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid got %b exp 1", bus.valid); end
      n_checks++; if (bus.overrun !== 1'b0) begin n_fail++; $display("FAIL b2b_ovr got %b exp 0", bus.overrun); end
      drain();
   endtask

   task automatic test_frame_err;
      bus.ready = 1'b1;
      send_frame(8'h5A, 1'b0, 1'b0, 0, 1'b1);
      n_checks++; if (bus.frame_err !== 1'b1) begin n_fail++; $display("FAIL ferr_pulse got %b exp 1", bus.frame_err); end
      n_checks++; if (bus.valid !== 1'b0) begin n_fail++; $display("FAIL ferr_valid got %b exp 0", bus.valid); end
      n_checks++; if (bus.overrun !== 1'b0) begin n_fail++; $display("FAIL ferr_ovr got %b exp 0", bus.overrun); end
      @(negedge clk);
      n_checks++; if (bus.frame_err !== 1'b0) begin n_fail++; $display("FAIL ferr_1cyc got %b exp 0", bus.frame_err); end
      send_frame(8'h01, 1'b1, 1'b0, 0, 1'b1);
      n_checks++; if (bus.data !== 8'h01) begin n_fail++; $display("FAIL ferr_next_data got %h exp 01", bus.data); end
      n_checks++; if (bus.valid !== 1'b1) begin n_fail++; $display("FAIL ferr_next_valid got %b exp 1", bus.valid); end
      @(negedge clk);
      bus.ready = 1'b0;
   endtask

`ifdef PARITY_CHECK_EN
   task automatic test_parity;
      bus.ready = 1'b1;
      send_frame(8'h07, 1'b1, 1'b1, 0, 1'b1);
      n_checks++; if (bus.frame_err !== 1'b1) begin n_fail++; $display("FAIL par_bad_ferr got %b exp 1", bus.frame_err); end
      n_checks++; if (bus.valid !== 1'b0) begin n_fail++; $display("FAIL par_bad_valid got %b exp 0", bus.valid); end
      send_frame(8'h07, 1'b1, 1'b0, 0, 1'b1);
      n_checks++; if (bus.data !== 8'h07) begin n_fail++; $display("FAIL par_ok_data got %h exp 07", bus.data); end
      n_checks++; if (bus.frame_err !== 1'b0) begin n_fail++; $display("FAIL par_ok_ferr got %b exp 0", bus.frame_err); end
      @(negedge clk);
      bus.ready = 1'b0;
   endtask
`endif

   task automatic test_reset_mid;
      bus.ready = 1'b0;
      send_frame(8'h99, 1'b1, 1'b0, 0, 1'b0);
      drive_bit(1'b0, 0);
      for (int i = 0; i < 3; i++) drive_bit(1'b1, 0);
      #2 clr_n = 1'b0;
      #1;
      n_checks++; if (bus.valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_valid got %b exp 0", bus.valid); end
      n_checks++; if (bus.data !== 8'h00) begin n_fail++; $display("FAIL rstmid_data got %h exp 00", bus.data); end
      @(negedge clk);
      clr_n = 1'b1;
      @(negedge clk);
      bus.ready = 1'b1;
      send_frame(8'hFF, 1'b1, 1'b0, 0, 1'b1);
      n_checks++; if (bus.data !== 8'hFF) begin n_fail++; $display("FAIL rstmid_next_data got %h exp ff", bus.data); end
      n_checks++; if (bus.valid !== 1'b1) begin n_fail++; $display("FAIL rstmid_next_valid got %b exp 1", bus.valid); end
      n_checks++; if (bus.frame_err !== 1'b0) begin n_fail++; $display("FAIL rstmid_ferr got %b exp 0", bus.frame_err); end
   endtask

   initial begin
      bus.ready = 1'b0;
      test_reset();
      test_basic();
      test_slow_hold();
      test_overrun();
      test_frame_err();
`ifdef PARITY_CHECK_EN
      test_parity();
`endif
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/serial_frame_rx.md
Name: serial_frame_rx

Overview:
- Serial-to-parallel frame receiver that sits directly downstream of the 2-bit shift register chain and consumes its serial output stream.
- Detects a start bit and shifts in DATA_W data bits, LSB first.
- Checks an optional even-parity bit and the stop bit.
- Presents each completed word on a registered parallel output with a valid/ready handshake to the next consumer.

Parameters:
- DATA_W, 8, number of data bits per frame (legal range 2..16).

Ports:
- clk  input  1  system clock, all state updates on posedge.
- clr_n  input  1  asynchronous active-low reset.
- serial_in  input  1  serial bit stream; line idles high.
- bit_en  input  1  bit strobe; serial_in is sampled only on cycles with bit_en=1.
- data_out  output  DATA_W  received word.
- data_valid  output  1  data_out holds an unconsumed word.
- data_ready  input  1  consumer accepts the word when data_valid && data_ready.
- frame_err  output  1  one-cycle pulse: bad stop bit or bad parity.
- overrun  output  1  one-cycle pulse: a completed frame was dropped because the output was still full.

Behaviour:
- Reset (clr_n=0, asynchronous): state=IDLE, bit counter=0, shift register=0, data_out=0, data_valid=0, frame_err=0, overrun=0.
- Cycles with bit_en=0: the FSM, counter and shift register hold. The output handshake still operates every cycle.
- States, evaluated only on bit_en=1 cycles:
  - IDLE: serial_in=0 -> DATA, counter=0. serial_in=1 -> stay in IDLE.
  - DATA: shift serial_in into bit [counter] (LSB first), counter+1. When counter reaches DATA_W-1 -> PARITY if PARITY_CHECK_EN is defined, else STOP.
  - PARITY: compare serial_in with the XOR of the received data bits (even parity). A mismatch sets an internal parity-bad flag. -> STOP.
  - STOP: serial_in=1 and parity OK -> frame good. serial_in=0 or parity bad -> frame_err=1 for one cycle, word discarded. Always -> IDLE.
- Good-frame delivery, on the STOP sampling edge:
  - data_valid=0: load data_out, set data_valid=1. Both are visible the cycle after the edge.
  - data_valid=1 and data_ready=1 in the same cycle: the old word is consumed, the new word is loaded, data_valid stays 1, no overrun.
  - data_valid=1 and data_ready=0: the new word is dropped, overrun=1 for one cycle, data_out is unchanged.
- Handshake:
  - data_valid && data_ready with no new good frame -> data_valid=0 next cycle. data_out holds its last value.
  - data_out must not change while data_valid=1 and no transfer occurs.
- Latency: data_valid rises one clk after the bit_en edge that samples the stop bit.
- A start bit sampled in IDLE while data_valid=1 is legal; reception proceeds in parallel with the pending word.
- Reset asserted mid-frame: the partial frame is abandoned with no error pulse, and all outputs return to reset values immediately.
- frame_err and overrun are never asserted together; a bad frame is never counted as an overrun.

Optional Feature:
- Macro PARITY_CHECK_EN.
- Defined: each frame is start + DATA_W data + 1 even-parity bit + stop. A parity mismatch pulses frame_err and drops the word.
- Undefined: each frame is start + DATA_W data + stop. No PARITY state and no parity logic exist.

Test Plan:
- Reset, then with bit_en=1 every cycle and data_ready=1, send start 0, data 0xA5 LSB first, stop 1 (plus parity 0 if enabled) -> data_out=0xA5, data_valid high for exactly 1 cycle, frame_err=0.
- bit_en=1 every 4th cycle, data_ready=0, send 0x3C -> data_valid=1 and data_out=0x3C hold indefinitely. Raise data_ready for 1 cycle -> data_valid=0 next cycle.
- data_ready=0, send 0x11 then 0x22 -> data_out stays 0x11, overrun pulses once at the 0x22 stop edge. Repeat with data_ready=1 at that edge -> data_out=0x22, no overrun.
- Send 0x5A with stop bit=0 -> frame_err one-cycle pulse, data_valid stays 0, FSM back in IDLE. Next frame 0x01 is received correctly.
- PARITY_CHECK_EN defined, send 0x07 with parity=0 (correct is 1) -> frame_err pulse, no data_valid. Send 0x07 with parity=1 -> data_out=0x07.
- Assert clr_n=0 after 3 data bits of a frame, release, send 0xFF -> no frame_err, data_out=0xFF.
